// File: rtl/mux64_pkg.sv
// Shared types and constants for the 64-bit serializer slice.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package mux64_pkg;

  // Word width, bit-select width and length-field width. The length field is
  // one bit wider than the select so that it can hold the value 64.
  localparam int DATA_W = 64;
  localparam int SEL_W  = 6;
  localparam int LEN_W  = 7;

  // Serializer control states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // A requested length of 0 means a full word.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
    eff_len = (len == '0) ? LEN_W'(DATA_W) : len;
  endfunction

endpackage : mux64_pkg

// File: rtl/mux64_1.sv
// 64:1 bit multiplexer: out = in[select].
// Latency: purely combinational, zero cycles.
// Backpressure: none; no flow control at this level.
//
// Ports:
//   in     - 64-bit word to pick from
//   select - bit index 0..63
//   out    - selected bit
module mux64_1
  import mux64_pkg::*;
(
  input  logic [DATA_W-1:0] in,
  input  logic [SEL_W-1:0]  select,
  output logic              out
);

  assign out = in[select];

endmodule : mux64_1

// File: rtl/mux64_serializer.sv
// Parallel-to-serial converter: emits 1..64 bits of a captured word, one per beat.
// Latency: first bit is valid the cycle after the input handshake.
// Backpressure: out_ready=0 freezes the current bit; in_ready is only offered
//   when idle or on the consumed last beat, so a new word follows with no gap.
//
// Ports:
//   clk, rst_n          - clock and asynchronous active-low reset
//   in_data, in_len     - word to serialize and number of bits (0 means 64)
//   in_valid, in_ready  - input handshake
//   out_bit, out_last   - current serial bit and end-of-word marker
//   out_valid, out_ready- output handshake
//   busy                - a word is being serialized
module mux64_serializer
  import mux64_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [LEN_W-1:0]  in_len,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DATA_W - 1);

  // State registers and their next-state values.
  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [LEN_W-1:0]  len_q,   len_d;
  logic [LEN_W-1:0]  cnt_q,   cnt_d;

  // Handshake qualifiers.
  logic              in_hs;
  logic              out_hs;
  logic [SEL_W-1:0]  bit_sel;

  // ---------------------------------------------------------------------------
  // Output-side control
  // ---------------------------------------------------------------------------
  assign out_valid = (state_q == SHIFT);
  assign busy      = out_valid;

  // cnt_q only ranges 0..len_q-1 while shifting, so the compare never sees
  // the post-word value.
  assign out_last  = out_valid && (cnt_q == (len_q - LEN_W'(1)));

  // Accept a new word when idle, or when the final bit is leaving this cycle.
  assign in_ready  = (state_q == IDLE) || (out_last && out_ready);

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;

  // Only the low six counter bits drive the select; while shifting the
  // counter stays below 64, so the select never wraps.
  always_comb begin
    bit_sel = cnt_q[SEL_W-1:0];
    if (MSB_FIRST) begin
      bit_sel = SEL_MAX - cnt_q[SEL_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Bit picker
  // ---------------------------------------------------------------------------
  mux64_1 u_mux (
    .in     (data_q),
    .select (bit_sel),
    .out    (out_bit)
  );

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    len_d   = len_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      IDLE: begin
        // out_ready is irrelevant here; only a new word moves us on.
        if (in_hs) begin
          data_d  = in_data;
          len_d   = eff_len(in_len);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (out_hs) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (out_last) begin
            state_d = IDLE;
          end
        end
        // A load on the final beat overrides the increment and keeps shifting.
        // in_hs cannot be true on earlier beats because in_ready is low then.
        if (in_hs) begin
          data_d  = in_data;
          len_d   = eff_len(in_len);
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Clearing data_q on reset also forces out_bit low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      len_q  <= len_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule : mux64_serializer

// File: tb/tb_mux64_serializer.sv
// Bench for mux64_serializer: drives both bit orders from one stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_mux64_serializer;

  logic        clk;
  logic        rst_n;
  logic [63:0] in_data;
  logic [6:0]  in_len;
  logic        in_valid;
  logic        out_ready;

  logic in_ready_l, out_bit_l, out_valid_l, out_last_l, busy_l;
  logic in_ready_m, out_bit_m, out_valid_m, out_last_m, busy_m;

  int checks = 0;
  int errors = 0;

  mux64_serializer #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_l), .out_bit(out_bit_l),
    .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
    .busy(busy_l)
  );

  mux64_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_len(in_len),
    .in_valid(in_valid), .in_ready(in_ready_m), .out_bit(out_bit_m),
    .out_valid(out_valid_m), .out_ready(out_ready), .out_last(out_last_m),
    .busy(busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One vector: a word, its length field, the number of beats, the expected
  // bit stream for each order (bit k = k-th emitted bit) and an out_ready
  // pattern indexed by cycle number modulo 16.
  typedef struct {
    logic [63:0] data;
    logic [6:0]  len;
    int          n;
    logic [63:0] exp_l;
    logic [63:0] exp_m;
    logic [15:0] rp;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ":valid_l"}, 64'(out_valid_l), 64'd0);
    chk({nm, ":valid_m"}, 64'(out_valid_m), 64'd0);
    chk({nm, ":busy"},    64'(busy_l),      64'd0);
    chk({nm, ":last"},    64'(out_last_l),  64'd0);
    chk({nm, ":in_rdy"},  64'(in_ready_l),  64'd1);
  endtask

  // Present one word at a negedge, then walk its beats under the given
  // out_ready pattern, checking every cycle.
  task automatic run_word(input vec_t v, input string nm);
    int k;
    int cyc;
    @(negedge clk);
    chk({nm, ":pre_in_rdy"}, 64'(in_ready_l), 64'd1);
    in_data  = v.data;
    in_len   = v.len;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    k   = 0;
    cyc = 0;
    while (k < v.n && cyc < 4 * v.n + 20) begin
      out_ready = v.rp[cyc % 16];
      @(negedge clk);
      chk({nm, ":valid_l"}, 64'(out_valid_l), 64'd1);
      chk({nm, ":valid_m"}, 64'(out_valid_m), 64'd1);
      chk({nm, ":bit_l"},   64'(out_bit_l),   64'(v.exp_l[k]));
      chk({nm, ":bit_m"},   64'(out_bit_m),   64'(v.exp_m[k]));
      chk({nm, ":last_l"},  64'(out_last_l),  64'(k == v.n - 1));
      chk({nm, ":last_m"},  64'(out_last_m),  64'(k == v.n - 1));
      chk({nm, ":in_rdy"},  64'(in_ready_l),  64'((k == v.n - 1) && out_ready));
      @(posedge clk);
      #1;
      if (out_ready) k++;
      cyc++;
    end
    if (k < v.n) begin
      chk({nm, ":timeout_beats"}, 64'(k), 64'(v.n));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({nm, ":after"}, 64'(out_valid_l), 64'd0);
    chk({nm, ":after_busy"}, 64'(busy_m), 64'd0);
  endtask

  initial begin
    vecs[0] = '{64'h8000_0000_0000_0001, 7'd4,  4,  64'h1,                  64'h1,   16'hFFFF};
    vecs[1] = '{64'hA000_0000_0000_0000, 7'd0,  64, 64'hA000_0000_0000_0000, 64'h5,   16'hFFFF};
    vecs[2] = '{64'h0000_0000_0000_00F0, 7'd8,  8,  64'hF0,                 64'h0,   16'hFFFF};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 7'd1,  1,  64'h1,                  64'h1,   16'hFFFF};
    vecs[4] = '{64'h1234_5678_9ABC_DEF0, 7'd16, 16, 64'hDEF0,               64'h2C48, 16'hFFFF};
    vecs[5] = '{64'h8000_0000_0000_0001, 7'd64, 64, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 16'hFFFF};
    vecs[6] = '{64'h0000_0000_0000_000D, 7'd4,  4,  64'hD,                  64'h0,   16'hFFF9};
    vecs[7] = '{64'h0000_0000_0000_0005, 7'd3,  3,  64'h5,                  64'h0,   16'hFFF3};

    rst_n     = 1'b0;
    in_data   = '0;
    in_len    = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state.
    #3;
    chk_idle("reset");
    chk("reset:bit_l", 64'(out_bit_l), 64'd0);
    chk("reset:bit_m", 64'(out_bit_m), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // out_ready while idle does nothing.
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_idle("idle_rdy");
    end

    // Table-driven words.
    for (int i = 0; i < 8; i++) begin
      run_word(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back words, with a junk word offered mid-word that must be ignored.
    @(negedge clk);
    in_data   = 64'h8000_0000_0000_0002;
    in_len    = 7'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_data = 64'hFFFF_FFFF_FFFF_FFFF;
    in_len  = 7'd0;
    @(negedge clk);
    chk("b2b:beat0_in_rdy", 64'(in_ready_l), 64'd0);
    chk("b2b:beat0_bit_l",  64'(out_bit_l),  64'd0);
    chk("b2b:beat0_bit_m",  64'(out_bit_m),  64'd1);
    @(posedge clk);
    #1;
    in_data = 64'h4000_0000_0000_0005;
    in_len  = 7'd3;
    @(negedge clk);
    chk("b2b:beat1_in_rdy", 64'(in_ready_l), 64'd1);
    chk("b2b:beat1_last",   64'(out_last_l), 64'd1);
    chk("b2b:beat1_bit_l",  64'(out_bit_l),  64'd1);
    chk("b2b:beat1_bit_m",  64'(out_bit_m),  64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      logic [2:0] el;
      logic [2:0] em;
      el = 3'b101;
      em = 3'b010;
      @(negedge clk);
      chk("b2b:w2_valid", 64'(out_valid_l), 64'd1);
      chk("b2b:w2_bit_l", 64'(out_bit_l),   64'(el[k]));
      chk("b2b:w2_bit_m", 64'(out_bit_m),   64'(em[k]));
      chk("b2b:w2_last",  64'(out_last_l),  64'(k == 2));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    chk_idle("b2b:end");

    // Mid-word asynchronous reset at beat 10 of a full word.
    in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    in_len   = 7'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst:pre_valid", 64'(out_valid_l), 64'd1);
    chk("rst:pre_bit",   64'(out_bit_l),   64'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("rst:during");
    chk("rst:bit_l", 64'(out_bit_l), 64'd0);
    chk("rst:bit_m", 64'(out_bit_m), 64'd0);
    #1;
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk_idle("rst:after");
    end

    // Normal operation resumes after reset.
    run_word(vecs[0], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute guard so a stuck run still reports and stops.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_mux64_serializer

// File: doc/mux64_serializer.md
MUX64_SERIALIZER -- requirements
Module: mux64_serializer

Interface
REQ-001 The block SHALL have one parameter, MSB_FIRST, default 0: 0 emits bit 0 first; 1 emits bit 63 first.
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have a port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have a port in_data, input, 64 bits: parallel word to serialize.
REQ-005 The block SHALL have a port in_len, input, 7 bits: number of bits to emit; 1..64 are legal, and 0 is treated as 64.
REQ-006 The block SHALL have a port in_valid, input, 1 bit: upstream word available.
REQ-007 The block SHALL have a port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-008 The block SHALL have a port out_bit, output, 1 bit: current serial bit.
REQ-009 The block SHALL have a port out_valid, output, 1 bit: out_bit is valid.
REQ-010 The block SHALL have a port out_ready, input, 1 bit: downstream consumes out_bit this cycle.
REQ-011 The block SHALL have a port out_last, output, 1 bit: the current bit is the final bit of the word.
REQ-012 The block SHALL have a port busy, output, 1 bit: high while a word is being serialized.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-014 An input handshake occurs when in_valid=1 and in_ready=1; a handshake SHALL capture in_data into data_q and the effective length into len_q, clear the beat counter cnt_q to 0, and move the FSM to SHIFT.
REQ-015 in_ready SHALL be 1 in IDLE, and also in SHIFT when out_last=1 and out_ready=1; this gives zero-bubble back-to-back words.
REQ-016 The first bit of an accepted word SHALL appear on out_bit with out_valid=1 in the cycle after the input handshake (latency 1).
REQ-017 In SHIFT, out_valid SHALL be 1; in IDLE, out_valid SHALL be 0; busy SHALL equal out_valid.
REQ-018 The bit select SHALL be cnt_q[5:0] when MSB_FIRST=0, and 63-cnt_q[5:0] when MSB_FIRST=1.
REQ-019 out_bit SHALL be data_q indexed by the bit select, taken through the 64:1 mux sub-module.
REQ-020 An output handshake occurs when out_valid=1 and out_ready=1; each output handshake SHALL increment cnt_q by 1.
REQ-021 out_last SHALL be 1 exactly when out_valid=1 and cnt_q equals len_q-1.
REQ-022 On an output handshake with out_last=1, the FSM SHALL return to IDLE, unless a new input handshake happens in the same cycle, in which case it SHALL reload per REQ-014 and stay in SHIFT.
REQ-023 While out_valid=1 and out_ready=0, out_bit, out_last, data_q and cnt_q SHALL hold stable.
REQ-024 For len=64, cnt_q SHALL run 0..63; the 7-bit counter SHALL never wrap in the select path.
REQ-025 While in SHIFT and not on the last beat, in_valid SHALL be ignored and data_q SHALL NOT be overwritten.
REQ-026 out_ready asserted while in IDLE SHALL have no effect.

Reset
REQ-027 Asserting rst_n=0 SHALL immediately, without waiting for clk, force the FSM to IDLE and clear data_q, len_q and cnt_q to 0.
REQ-028 During and after reset, out_valid, out_last and busy SHALL be 0, out_bit SHALL be 0, and in_ready SHALL be 1.
REQ-029 Reset asserted mid-word SHALL abandon the word; no further bits of that word SHALL be emitted after reset is released.

Structure
REQ-030 A shared package mux64_pkg SHALL hold the state enum (IDLE, SHIFT) and the constants DATA_W=64, SEL_W=6 and LEN_W=7.
REQ-031 The block SHALL instantiate exactly one mux64_1 as its only sub-module, with in=data_q, select=the computed bit select, and out=out_bit.
REQ-032 All other logic (FSM, counter, handshake) SHALL reside in mux64_serializer.

Verification
REQ-033 Basic LSB-first: MSB_FIRST=0, in_data=64'h8000_0000_0000_0001, in_len=4, out_ready=1 -> out_bit sequence 1,0,0,0 on four consecutive cycles; out_last=1 only on the 4th; then IDLE.
REQ-034 Full word MSB-first: MSB_FIRST=1, in_data=64'hA000_0000_0000_0000, in_len=0 -> 64 bits emitted starting 1,0,1,0, then 60 zeros; out_last=1 on beat 64.
REQ-035 Backpressure: out_ready toggled 1,0,0,1 during a word -> out_bit and out_last stable through the stalls; no bit skipped or duplicated.
REQ-036 Back-to-back: second word presented with in_valid=1 during the first word's last beat -> in_ready=1 that cycle; second word's first bit appears the next cycle with no idle gap.
REQ-037 Mid-word reset: rst_n=0 pulsed between clock edges at beat 10 of 64 -> out_valid=0 immediately; no further bits of that word emitted after release.
